// File: rtl/pll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_pkg
// Description : Shared widths, state encoding and helpers for PLL trim monitors.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_pkg;

    localparam int TRIM_W   = 26;
    localparam int CODE_W   = 5;
    localparam int CODE_MAX = 26;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trim_popcount.sv
`default_nettype none
// ============================================================================
// Module      : trim_popcount
// Description : Combinational population count of a DCO trim word.
// Revision    : 1.0 - initial release
// ============================================================================
module trim_popcount
    import pll_pkg::*;
(
    input  logic [TRIM_W-1:0] i_trim,
    output logic [CODE_W-1:0] o_code
);

    always_comb begin
        o_code = '0;
        for (int i = 0; i < TRIM_W; i++) begin
            o_code = o_code + CODE_W'(i_trim[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pll_lock_detector.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_detector
// Description : Windowed trim-stability lock detector with rail-saturation flags.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_detector
    import pll_pkg::*;
#(
    parameter int WINDOW       = 64,
    parameter int TOL          = 1,
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 2,
    parameter int SAT_COUNT    = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [TRIM_W-1:0] trim,
    output logic [CODE_W-1:0] trim_code,
    output logic              locked,
    output logic              lock_lost,
    output logic              sat_hi,
    output logic              sat_lo
);

    localparam int                c_WIN_W    = $clog2(WINDOW);
    localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(WINDOW - 1);

    state_t              r_state;
    logic [c_WIN_W-1:0]  r_win_cnt;
    logic [CODE_W-1:0]   r_min;
    logic [CODE_W-1:0]   r_max;
    logic                r_eval;
    logic                r_eval_stable;
    logic                r_eval_hi;
    logic                r_eval_lo;
    logic [7:0]          r_stable_cnt;
    logic [7:0]          r_unstable_cnt;
    logic [7:0]          r_sat_hi_cnt;
    logic [7:0]          r_sat_lo_cnt;

    logic [CODE_W-1:0]   w_code;
    logic [CODE_W-1:0]   w_min;
    logic [CODE_W-1:0]   w_max;
    logic                w_stable;
    logic [7:0]          w_stable_inc;
    logic [7:0]          w_unstable_inc;
    logic [7:0]          w_sat_hi_inc;
    logic [7:0]          w_sat_lo_inc;

    trim_popcount u_popcount (
        .i_trim (trim),
        .o_code (w_code)
    );

    // Extremes including the current cycle, so the last window cycle is counted.
    assign w_min    = (trim_code < r_min) ? trim_code : r_min;
    assign w_max    = (trim_code > r_max) ? trim_code : r_max;
    assign w_stable = ((w_max - w_min) <= CODE_W'(TOL)) &&
                      (w_min != CODE_W'(CODE_MAX)) && (w_max != '0);

    assign w_stable_inc   = sat_inc(r_stable_cnt);
    assign w_unstable_inc = sat_inc(r_unstable_cnt);
    assign w_sat_hi_inc   = sat_inc(r_sat_hi_cnt);
    assign w_sat_lo_inc   = sat_inc(r_sat_lo_cnt);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= IDLE;
            r_win_cnt      <= '0;
            r_min          <= '0;
            r_max          <= '0;
            r_eval         <= 1'b0;
            r_eval_stable  <= 1'b0;
            r_eval_hi      <= 1'b0;
            r_eval_lo      <= 1'b0;
            r_stable_cnt   <= '0;
            r_unstable_cnt <= '0;
            r_sat_hi_cnt   <= '0;
            r_sat_lo_cnt   <= '0;
            trim_code      <= '0;
            locked         <= 1'b0;
            lock_lost      <= 1'b0;
            sat_hi         <= 1'b0;
            sat_lo         <= 1'b0;
        end else begin
            trim_code <= w_code;
            lock_lost <= 1'b0;
            r_eval    <= 1'b0;
            if (!enable) begin
                r_state        <= IDLE;
                r_win_cnt      <= '0;
                r_min          <= '0;
                r_max          <= '0;
                r_stable_cnt   <= '0;
                r_unstable_cnt <= '0;
                r_sat_hi_cnt   <= '0;
                r_sat_lo_cnt   <= '0;
                locked         <= 1'b0;
                sat_hi         <= 1'b0;
                sat_lo         <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state   <= SEEK;
                        r_win_cnt <= '0;
                    end
                    SEEK, LOCKED: begin
                        if (r_win_cnt == '0) begin
                            r_min <= trim_code;
                            r_max <= trim_code;
                        end else begin
                            r_min <= w_min;
                            r_max <= w_max;
                        end
                        // Window verdict is registered and acted on one edge later.
                        if (r_win_cnt == c_WIN_LAST) begin
                            r_win_cnt     <= '0;
                            r_eval        <= 1'b1;
                            r_eval_stable <= w_stable;
                            r_eval_hi     <= (w_min == CODE_W'(CODE_MAX));
                            r_eval_lo     <= (w_max == '0);
                        end else begin
                            r_win_cnt <= r_win_cnt + c_WIN_W'(1);
                        end
                        if (r_eval) begin
                            if (r_eval_hi) begin
                                r_sat_hi_cnt <= w_sat_hi_inc;
                                sat_hi       <= (w_sat_hi_inc >= 8'(SAT_COUNT));
                            end else begin
                                r_sat_hi_cnt <= '0;
                                sat_hi       <= 1'b0;
                            end
                            if (r_eval_lo) begin
                                r_sat_lo_cnt <= w_sat_lo_inc;
                                sat_lo       <= (w_sat_lo_inc >= 8'(SAT_COUNT));
                            end else begin
                                r_sat_lo_cnt <= '0;
                                sat_lo       <= 1'b0;
                            end
                            if (r_state == SEEK) begin
                                if (!r_eval_stable) begin
                                    r_stable_cnt <= '0;
                                end else if (w_stable_inc >= 8'(LOCK_COUNT)) begin
                                    r_state      <= LOCKED;
                                    locked       <= 1'b1;
                                    r_stable_cnt <= '0;
                                end else begin
                                    r_stable_cnt <= w_stable_inc;
                                end
                            end else begin
                                if (r_eval_stable) begin
                                    r_unstable_cnt <= '0;
                                end else if (w_unstable_inc >= 8'(UNLOCK_COUNT)) begin
                                    r_state        <= SEEK;
                                    locked         <= 1'b0;
                                    lock_lost      <= 1'b1;
                                    r_unstable_cnt <= '0;
                                end else begin
                                    r_unstable_cnt <= w_unstable_inc;
                                end
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_detector
// Description : Directed self-checking bench for pll_lock_detector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_detector;

    localparam logic [25:0] c_C0  = 26'h0000000;
    localparam logic [25:0] c_C10 = 26'h00003FF;
    localparam logic [25:0] c_C11 = 26'h00007FF;
    localparam logic [25:0] c_C12 = 26'h0000FFF;
    localparam logic [25:0] c_C20 = 26'h00FFFFF;
    localparam logic [25:0] c_C25 = 26'h1FFFFFF;
    localparam logic [25:0] c_C26 = 26'h3FFFFFF;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [25:0] trim;
    logic [4:0]  trim_code;
    logic        locked;
    logic        lock_lost;
    logic        sat_hi;
    logic        sat_lo;

    int   checks;
    int   errors;
    logic all_locked;
    logic any_locked;
    logic any_lost;
    logic any_sat;

    pll_lock_detector #(
        .WINDOW       (16),
        .TOL          (1),
        .LOCK_COUNT   (4),
        .UNLOCK_COUNT (2),
        .SAT_COUNT    (2)
    ) dut (
        .clock     (clk),
        .reset     (reset),
        .enable    (enable),
        .trim      (trim),
        .trim_code (trim_code),
        .locked    (locked),
        .lock_lost (lock_lost),
        .sat_hi    (sat_hi),
        .sat_lo    (sat_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_acc();
        all_locked = 1'b1;
        any_locked = 1'b0;
        any_lost   = 1'b0;
        any_sat    = 1'b0;
    endtask

    // Drive n edges alternating a/b (a first), sampling 1ns after each edge.
    task automatic run(input logic [25:0] a, input logic [25:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            trim = (i % 2 == 0) ? a : b;
            @(posedge clk);
            #1;
            all_locked = all_locked & locked;
            any_locked = any_locked | locked;
            any_lost   = any_lost | lock_lost;
            any_sat    = any_sat | sat_hi | sat_lo;
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        trim   = c_C0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clr_acc();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr_acc();

        // Reset state
        do_reset();
        chk("rst_code",   32'(trim_code), 32'd0);
        chk("rst_locked", 32'(locked),    32'd0);
        chk("rst_lost",   32'(lock_lost), 32'd0);
        chk("rst_sat",    32'({sat_hi, sat_lo}), 32'd0);

        // 1: steady code 10, lock exactly 65 edges after the enable edge
        enable = 1'b1;
        run(c_C10, c_C10, 1);
        chk("s1_code", 32'(trim_code), 32'd10);
        run(c_C10, c_C10, 64);
        chk("s1_prelock", 32'(any_locked), 32'd0);
        run(c_C10, c_C10, 1);
        chk("s1_locked", 32'(locked), 32'd1);
        chk("s1_nolost", 32'(any_lost), 32'd0);
        chk("s1_nosat",  32'(any_sat),  32'd0);

        // 2a: alternating 10/11 locks like steady trim
        do_reset();
        enable = 1'b1;
        run(c_C10, c_C11, 1);
        chk("s2_code10", 32'(trim_code), 32'd10);
        run(c_C11, c_C10, 1);
        chk("s2_code11", 32'(trim_code), 32'd11);
        run(c_C10, c_C11, 63);
        chk("s2_prelock", 32'(any_locked), 32'd0);
        run(c_C11, c_C10, 1);
        chk("s2_locked", 32'(locked), 32'd1);

        // 2b: alternating 10/12 exceeds tolerance
        do_reset();
        enable = 1'b1;
        run(c_C10, c_C12, 200);
        chk("s2_nolock", 32'(any_locked), 32'd0);

        // 3: one noisy window is tolerated, two unlock with a single pulse
        do_reset();
        enable = 1'b1;
        run(c_C10, c_C10, 66);
        chk("s3_locked", 32'(locked), 32'd1);
        clr_acc();
        run(c_C20, c_C10, 14);
        run(c_C20, c_C20, 32);
        chk("s3_hold", 32'(all_locked), 32'd1);
        chk("s3_hold_nolost", 32'(any_lost), 32'd0);
        chk("s3_code20", 32'(trim_code), 32'd20);
        run(c_C20, c_C10, 32);
        chk("s3_hold2", 32'(all_locked), 32'd1);
        run(c_C20, c_C20, 1);
        chk("s3_pre_drop", 32'(locked), 32'd1);
        chk("s3_pre_lost", 32'(lock_lost), 32'd0);
        run(c_C20, c_C20, 1);
        chk("s3_drop", 32'(locked), 32'd0);
        chk("s3_lost", 32'(lock_lost), 32'd1);
        run(c_C20, c_C20, 1);
        chk("s3_lost_end", 32'(lock_lost), 32'd0);

        // 4: all ones saturates high, then code 25 recovers and locks
        do_reset();
        enable = 1'b1;
        run(c_C26, c_C26, 33);
        chk("s4_code26", 32'(trim_code), 32'd26);
        chk("s4_presat", 32'(sat_hi), 32'd0);
        run(c_C26, c_C26, 1);
        chk("s4_sat_hi", 32'(sat_hi), 32'd1);
        chk("s4_sat_lo", 32'(sat_lo), 32'd0);
        run(c_C26, c_C26, 14);
        run(c_C25, c_C25, 17);
        chk("s4_sat_hold", 32'(sat_hi), 32'd1);
        chk("s4_code25", 32'(trim_code), 32'd25);
        run(c_C25, c_C25, 1);
        chk("s4_sat_clr", 32'(sat_hi), 32'd0);
        run(c_C25, c_C25, 47);
        chk("s4_nolock", 32'(any_locked), 32'd0);
        run(c_C25, c_C25, 1);
        chk("s4_locked", 32'(locked), 32'd1);

        // 5: all zeros saturates low
        do_reset();
        enable = 1'b1;
        run(c_C0, c_C0, 33);
        chk("s5_presat", 32'(sat_lo), 32'd0);
        run(c_C0, c_C0, 1);
        chk("s5_sat_lo", 32'(sat_lo), 32'd1);
        chk("s5_sat_hi", 32'(sat_hi), 32'd0);
        chk("s5_nolock", 32'(any_locked), 32'd0);

        // 6a: disable while locked
        do_reset();
        enable = 1'b1;
        run(c_C10, c_C10, 66);
        chk("s6_locked", 32'(locked), 32'd1);
        enable = 1'b0;
        clr_acc();
        run(c_C10, c_C10, 1);
        chk("s6_dis_locked", 32'(locked), 32'd0);
        run(c_C10, c_C10, 2);
        chk("s6_dis_nolost", 32'(any_lost), 32'd0);

        // 6b: reset mid-window, then full relock time
        enable = 1'b1;
        run(c_C10, c_C10, 66);
        chk("s6_relocked", 32'(locked), 32'd1);
        run(c_C10, c_C10, 5);
        reset = 1'b1;
        run(c_C10, c_C10, 1);
        chk("s6_rst_out", 32'({trim_code, locked, lock_lost, sat_hi, sat_lo}), 32'd0);
        reset = 1'b0;
        clr_acc();
        run(c_C10, c_C10, 65);
        chk("s6_rst_prelock", 32'(any_locked), 32'd0);
        run(c_C10, c_C10, 1);
        chk("s6_rst_locked", 32'(locked), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
